// File: rtl/jt49_dly_pkg.sv
// Shared definitions for the jt49 delay arbiter.
// Holds the sequencer state encoding, default width constants and a helper
// that derives the per-channel region address width.
package jt49_dly_pkg;

  localparam int DW_DEF    = 8;   // sample width
  localparam int DEPTH_DEF = 10;  // total RAM address bits
  localparam int CHAW_DEF  = 2;   // channel-index bits
  localparam int CH_DEF    = 3;   // active channels

  // Sequencer states: clear RAM, wait for strobe, per-channel read/write, present
  typedef enum logic [2:0] {
    CLR  = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Address bits available inside one channel's region
  function automatic int region_bits(input int depth_p, input int chaw_p);
    return depth_p - chaw_p;
  endfunction

endpackage

// File: rtl/jt49_dly_arb_if.sv
// Bus bundle between the PSG mixer side and the delay arbiter.
// master: drives the sample strobe, packed input samples and delay config.
// slave : returns packed delayed samples, valid pulse, busy and overrun.
interface jt49_dly_arb_if #(
  parameter int dw    = 8,
  parameter int depth = 10,
  parameter int chaw  = 2,
  parameter int ch    = 3
);
  logic                  cen;
  logic [ch*dw-1:0]      din;
  logic [ch*dw-1:0]      dout;
  logic                  dout_valid;
  logic                  cfg_we;
  logic [chaw-1:0]       cfg_ch;
  logic [depth-chaw-1:0] cfg_len;
  logic                  busy;
  logic                  overrun;

  modport master (
    output cen, din, cfg_we, cfg_ch, cfg_len,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  cen, din, cfg_we, cfg_ch, cfg_len,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/jt49_dly_ram.sv
// Generic single-port RAM with a one-cycle registered read.
// Ports: clk; we_i write enable (has priority); re_i read enable;
// addr_i shared address; wd_i write data; q_o registered read data
// (holds its value when no read is issued).
module jt49_dly_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [aw-1:0] addr_i,
  input  logic [dw-1:0] wd_i,
  output logic [dw-1:0] q_o
);

  logic [dw-1:0] mem_q [2**aw];

  // Single access port: a write, or a registered read, never both
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wd_i;
    end else if (re_i) begin
      q_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/jt49_dly_arb.sv
// Time-multiplexes one single-port delay RAM among up to 2**chaw channels.
// After reset the whole RAM is cleared; then each sample strobe runs one
// read and one write per channel and presents all delayed samples at once.
// Ports: clk; rst (synchronous, active-high); bus (slave side of
// jt49_dly_arb_if: cen, din, cfg_we/cfg_ch/cfg_len in; dout, dout_valid,
// busy, overrun out).
module jt49_dly_arb
  import jt49_dly_pkg::*;
#(
  parameter int dw    = DW_DEF,
  parameter int depth = DEPTH_DEF,
  parameter int chaw  = CHAW_DEF,
  parameter int ch    = CH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  jt49_dly_arb_if.slave bus
);

  localparam int RW = region_bits(depth, chaw);
  localparam logic [chaw-1:0] LAST_C = chaw'(ch - 1);
  localparam logic [chaw:0]   CH_LIM = (chaw + 1)'(ch);

  state_t            state_q, state_d;
  logic [depth-1:0]  clr_addr_q, clr_addr_d;
  logic [chaw-1:0]   c_q, c_d;
  logic [RW-1:0]     wrpos_q, wrpos_d;
  logic [RW-1:0]     len_q     [ch];  // live config, written any time
  logic [RW-1:0]     len_lat_q [ch];  // snapshot used by the running frame
  logic [dw-1:0]     in_q      [ch];
  logic [dw-1:0]     shadow_q  [ch];
  logic [ch*dw-1:0]  dout_q;
  logic              dout_valid_q;
  logic              busy_q;
  logic              overrun_q;

  logic [RW-1:0]     cur_len_s;
  logic              bypass_s;
  logic [RW-1:0]     rd_off_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [depth-1:0]  ram_addr_s;
  logic [dw-1:0]     ram_wd_s;
  logic [dw-1:0]     ram_q_s;

  // Delay of the channel being serviced and its read offset in the region
  always_comb begin
    cur_len_s = len_lat_q[c_q];
    bypass_s  = (cur_len_s == {RW{1'b0}});
    rd_off_s  = wrpos_q - cur_len_s;  // wraps inside the channel region
  end

  // RAM port mux: exactly one access in CLR/RD/WR, none elsewhere
  always_comb begin
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = {depth{1'b0}};
    ram_wd_s   = {dw{1'b0}};
    case (state_q)
      CLR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_addr_q;
      end
      RD: begin
        ram_re_s   = ~bypass_s;
        ram_addr_s = {c_q, rd_off_s};
      end
      WR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = {c_q, wrpos_q};
        ram_wd_s   = in_q[c_q];
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  jt49_dly_ram #(
    .dw (dw),
    .aw (depth)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we_s),
    .re_i   (ram_re_s),
    .addr_i (ram_addr_s),
    .wd_i   (ram_wd_s),
    .q_o    (ram_q_s)
  );

  // Sequencer next-state logic
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    c_d        = c_q;
    wrpos_d    = wrpos_q;
    case (state_q)
      CLR: begin
        clr_addr_d = clr_addr_q + depth'(1'b1);
        if (clr_addr_q == {depth{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = CLR;
        end
      end
      IDLE: begin
        if (bus.cen) begin
          state_d = RD;
          c_d     = {chaw{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = WR;
      end
      WR: begin
        if (c_q == LAST_C) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          c_d     = c_q + chaw'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
        wrpos_d = wrpos_q + RW'(1'b1);
      end
      default: begin
        state_d = CLR;
      end
    endcase
  end

  // Sequencer state, clear pointer, channel index and write position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLR;
      clr_addr_q <= {depth{1'b0}};
      c_q        <= {chaw{1'b0}};
      wrpos_q    <= {RW{1'b0}};
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      c_q        <= c_d;
      wrpos_q    <= wrpos_d;
    end
  end

  // Delay-length config; out-of-range channels are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ch; i++) begin
        len_q[i] <= {RW{1'b0}};
      end
    end else if (bus.cfg_we && ({1'b0, bus.cfg_ch} < CH_LIM)) begin
      len_q[bus.cfg_ch] <= bus.cfg_len;
    end
  end

  // Frame snapshot, per-channel results, outputs and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ch; i++) begin
        in_q[i]      <= {dw{1'b0}};
        len_lat_q[i] <= {RW{1'b0}};
        shadow_q[i]  <= {dw{1'b0}};
      end
      dout_q       <= {(ch*dw){1'b0}};
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cen) begin
        for (int i = 0; i < ch; i++) begin
          in_q[i]      <= bus.din[i*dw +: dw];
          len_lat_q[i] <= len_q[i];
        end
      end
      if (state_q == WR) begin
        shadow_q[c_q] <= bypass_s ? in_q[c_q] : ram_q_s;
      end
      if (state_q == DONE) begin
        for (int i = 0; i < ch; i++) begin
          dout_q[i*dw +: dw] <= shadow_q[i];
        end
      end
      dout_valid_q <= (state_q == DONE);
      busy_q       <= (state_d != IDLE);
      // A strobe is only an overrun while a frame is running, not during clear
      if (bus.cen && state_q != IDLE && state_q != CLR) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_jt49_dly_arb.sv
// Self-checking bench for jt49_dly_arb (dw=8, depth=10, chaw=2, ch=3).
// Expected delayed samples come from a frame-history model: a sample taken in
// frame k must reappear in frame k+len, len=0 passes the current input, and
// anything older than the start of history reads as the cleared value 0.
module tb_jt49_dly_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jt49_dly_arb_if #(.dw(8), .depth(10), .chaw(2), .ch(3)) bus();

  jt49_dly_arb #(.dw(8), .depth(10), .chaw(2), .ch(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] hist [3][0:1023];
  int         mlen [3];
  int         nframes;

  typedef struct packed {
    logic [23:0] len;   // {ch2, ch1, ch0}
    logic [23:0] din;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] model_out(input logic [23:0] d);
    logic [23:0] r;
    r = 24'h0;
    for (int c = 0; c < 3; c++) begin
      if (mlen[c] == 0) r[c*8 +: 8] = d[c*8 +: 8];
      else if (nframes >= mlen[c]) r[c*8 +: 8] = hist[c][nframes - mlen[c]];
      else r[c*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  task automatic model_commit(input logic [23:0] d);
    for (int c = 0; c < 3; c++) hist[c][nframes] = d[c*8 +: 8];
    nframes++;
  endtask

  task automatic cfg_write(input int c, input int l);
    @(negedge clk);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = c[1:0];
    bus.cfg_len = l[7:0];
    if (c < 3) mlen[c] = l;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    int cnt;
    bit saw;
    @(negedge clk);
    rst = 1'b1;
    bus.cen = 1'b0;
    bus.cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    chk_v("rst_busy", 32'(bus.busy), 32'd1);
    chk_v("rst_dout", 32'(bus.dout), 32'd0);
    chk_v("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk_v("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    cnt = 0;
    saw = 1'b0;
    while (bus.busy === 1'b1 && cnt < 1100) begin
      bus.cen = (cnt == 100);
      @(negedge clk);
      cnt++;
      if (bus.dout_valid !== 1'b0) saw = 1'b1;
    end
    bus.cen = 1'b0;
    chk_v("clear_cycles", 32'(cnt), 32'd1024);
    chk_v("clear_no_valid", 32'(saw), 32'd0);
    chk_v("clear_overrun", 32'(bus.overrun), 32'd0);
    chk_v("clear_dout", 32'(bus.dout), 32'd0);
    nframes = 0;
    for (int c = 0; c < 3; c++) mlen[c] = 0;
  endtask

  // One frame: strobe, wait for the valid pulse, check latency and pulse width.
  task automatic run_frame(input logic [23:0] d, input bit mid, input int mch, input int mlv,
                           output logic [23:0] exp_o, output logic [23:0] got_o);
    int lat;
    exp_o = model_out(d);
    @(negedge clk);
    bus.din = d;
    bus.cen = 1'b1;
    @(negedge clk);
    bus.cen = 1'b0;
    lat = 0;
    while (bus.dout_valid !== 1'b1 && lat < 20) begin
      if (mid && lat == 2) begin
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = mch[1:0];
        bus.cfg_len = mlv[7:0];
        if (mch < 3) mlen[mch] = mlv;
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.cfg_we = 1'b0;
    chk_v($sformatf("latency_f%0d", nframes), 32'(lat), 32'd7);
    got_o = bus.dout;
    @(negedge clk);
    chk_v($sformatf("valid_pulse_f%0d", nframes), 32'(bus.dout_valid), 32'd0);
    model_commit(d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] e, g, d;
    int lat, hits, hit_frame, gap;

    tbl[0] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd20, 8'd10, 8'd0}, exp: {8'd0,  8'd0,   8'd0}};
    tbl[1] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd21, 8'd11, 8'd1}, exp: {8'd0,  8'd0,   8'd0}};
    tbl[2] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd22, 8'd12, 8'd2}, exp: {8'd0,  8'd10,  8'd1}};
    tbl[3] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd23, 8'd13, 8'd3}, exp: {8'd20, 8'd11,  8'd2}};
    tbl[4] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd24, 8'd14, 8'd4}, exp: {8'd21, 8'd12,  8'd3}};
    tbl[5] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd25, 8'd15, 8'd5}, exp: {8'd22, 8'd13,  8'd4}};
    tbl[6] = '{len: {8'd3, 8'd0, 8'd1}, din: {8'd26, 8'hA5, 8'd6}, exp: {8'd23, 8'hA5,  8'd5}};
    tbl[7] = '{len: {8'd3, 8'd2, 8'd1}, din: {8'd27, 8'd17, 8'd7}, exp: {8'd24, 8'd15,  8'd6}};

    bus.cen = 1'b0;
    bus.din = 24'h0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = 2'd0;
    bus.cfg_len = 8'd0;

    // reset release, clear timing, strobe ignored during clear
    do_reset();

    // table-driven ramp and bypass frames
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 3; c++)
        if (int'(tbl[i].len[c*8 +: 8]) != mlen[c]) cfg_write(c, int'(tbl[i].len[c*8 +: 8]));
      run_frame(tbl[i].din, 1'b0, 0, 0, e, g);
      chk_v($sformatf("table_row%0d", i), 32'(g), 32'(tbl[i].exp));
    end

    // overrun: second strobe three cycles after the first
    d = 24'h332211;
    e = model_out(d);
    @(negedge clk); bus.din = d; bus.cen = 1'b1;
    @(negedge clk); bus.cen = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.cen = 1'b1;
    @(negedge clk); bus.cen = 1'b0;
    lat = 3;
    while (bus.dout_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk_v("overrun_latency", 32'(lat), 32'd7);
    chk_v("overrun_frame_dout", 32'(bus.dout), 32'(e));
    chk_v("overrun_set", 32'(bus.overrun), 32'd1);
    model_commit(d);
    for (int i = 0; i < 2; i++) begin
      run_frame(24'h000000 | (i * 24'h010101), 1'b0, 0, 0, e, g);
      chk_v($sformatf("post_overrun_dout%0d", i), 32'(g), 32'(e));
      chk_v($sformatf("overrun_sticky%0d", i), 32'(bus.overrun), 32'd1);
    end
    do_reset();  // also checks overrun is cleared

    // max delay impulse on ch0, random traffic and len changes on ch1/ch2
    cfg_write(0, 255);
    hits = 0;
    hit_frame = -1;
    for (int k = 0; k <= 300; k++) begin
      if ($urandom_range(0, 15) == 0) cfg_write($urandom_range(1, 2), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 8));
      if ($urandom_range(0, 31) == 0) cfg_write(3, $urandom_range(0, 255));
      d[7:0]   = (k == 0) ? 8'h7F : 8'h00;
      d[15:8]  = 8'($urandom);
      d[23:16] = 8'($urandom);
      run_frame(d, 1'b0, 0, 0, e, g);
      chk_v($sformatf("rand_f%0d", k), 32'(g), 32'(e));
      if (g[7:0] == 8'h7F) begin
        hits++;
        hit_frame = k;
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    chk_v("impulse_count", 32'(hits), 32'd1);
    chk_v("impulse_frame", 32'(hit_frame), 32'd255);

    // mid-frame length change on ch2: 1 -> 4
    cfg_write(2, 1);
    for (int i = 0; i < 9; i++) begin
      d = {8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
      run_frame(d, (i == 5), 2, 4, e, g);
      chk_v($sformatf("midcfg_f%0d", i), 32'(g), 32'(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt49_dly_arb.md
Name: jt49_dly_arb

Overview:
- Time-multiplexes one single-port delay RAM among up to four audio channels.
- Each channel has its own programmable delay length.
- Sits in the filter path between the PSG channel mixer and the downstream filter stages; one shared block RAM replaces per-channel delay stages.
- On each sample strobe, a sequencer performs one read and one write per channel, then presents all delayed samples together.

Parameters:
- dw, 8: sample width in bits.
- depth, 10: total RAM address bits; RAM holds 2**depth words.
- chaw, 2: channel-index bits. Each channel owns a region of 2**(depth-chaw) words.
- ch, 3: number of active channels, 1..2**chaw.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cen  in  1  sample strobe; starts one frame.
- din  in  ch*dw  packed input samples; channel c occupies bits [c*dw +: dw].
- dout  out  ch*dw  packed delayed samples, same packing as din.
- dout_valid  out  1  one-cycle pulse when dout updates.
- cfg_we  in  1  delay-length write strobe.
- cfg_ch  in  chaw  channel selected by the write.
- cfg_len  in  depth-chaw  delay in samples; 0 = bypass.
- busy  out  1  high during clear or frame processing.
- overrun  out  1  sticky flag; set when cen arrives while a frame is in progress.

Behaviour:
- Reset values: dout=0, dout_valid=0, overrun=0, busy=1 (clear starts), all len registers=0, wrpos=0, FSM=CLR, clear address=0.
- CLR state:
  - Writes 0 to RAM address clr_addr, one word per cycle, for 2**depth cycles.
  - Moves to IDLE after the last address; busy drops on entry to IDLE.
  - cen during CLR is ignored and does not set overrun.
- IDLE:
  - On cen: latch din into in_q and the len registers into len_q, set c=0, go to RD.
- RD:
  - If len_q[c]==0, skip the RAM read; the channel is bypassed.
  - Otherwise drive the read address {c, wrpos - len_q[c]}, with subtraction mod 2**(depth-chaw).
  - Go to WR.
- WR:
  - Capture RAM q, or in_q[c] when bypassed, into shadow[c].
  - Write in_q[c] to {c, wrpos}.
  - If c==ch-1 go to DONE; else c++ and go to RD.
- DONE:
  - dout <= shadow (all channels at once); pulse dout_valid; wrpos++ (wraps).
  - Return to IDLE.
- Latency: dout_valid asserts 2*ch+1 cycles after the cen cycle; with ch=3, 7 cycles.
- Delay semantics:
  - A sample accepted in frame k appears on dout in frame k+len (len>=1).
  - len=0 outputs the same frame's input.
  - Maximum delay is 2**(depth-chaw)-1.
- Read-before-write ordering per channel: a frame never reads the word it writes.
- cen while FSM is not IDLE or CLR: ignored, overrun<=1. Only rst clears overrun.
- cfg_we:
  - Writes len[cfg_ch] in any state, including busy.
  - Takes effect at the next accepted cen, because len_q is latched there.
  - cfg_ch >= ch is ignored.
- Changing len mid-stream: output jumps to the sample at the new offset. There is no interpolation; stale-region data is acceptable.
- rst asserted mid-frame: aborts the frame, reinitialises every reset value, and reruns CLR. No partial dout_valid.
- RAM is inferred single-port with one-cycle registered read. Exactly one access occurs per cycle, and no read and write happen in the same cycle.

Decomposition:
- Shared package jt49_dly_pkg holds:
  - FSM state enum: CLR, IDLE, RD, WR, DONE.
  - Width constants derived from dw, depth and chaw.
- Sub-module jt49_dly_ram: generic single-port RAM with registered read and a write-enable port.
- All sequencing lives in jt49_dly_arb.

Test Plan:
- Reset release, ch=3, depth=10: busy high for exactly 1024 cycles, then low; dout=0; a cen pulsed during CLR produces no dout_valid and leaves overrun at 0.
- len={1,2,3}, din ramp where channel c gets 10*c+frame: after frame 5, dout = {4, 13, 22} for channels 0/1/2, with dout_valid exactly 7 cycles after cen.
- len[1]=0, din[1]=0xA5: dout[1]=0xA5 in the same frame; the other channels are unaffected.
- len[0]=255 (max), single impulse 0x7F at frame 0 then zeros: dout[0]=0x7F only at frame 255; exercises wrpos wrap across frames 256..300.
- cen pulses 3 cycles apart: the second cen is ignored, overrun=1 and stays 1 after further idle frames; rst clears it.
- cfg_we for channel 2 (len 1 -> 4) asserted mid-frame: the current frame still uses len 1, and the next frame outputs the sample from 4 frames back.
